// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 width codes
//   - FSM state encoding
//   - helpers for access size, legality and word-crossing detection
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Access size in bytes; 0 for codes that have no width.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        logic [2:0] size;
        case (funct3)
            F3_B, F3_BU: size = 3'd1;
            F3_H, F3_HU: size = 3'd2;
            F3_W:        size = 3'd4;
            default:     size = 3'd0;
        endcase
        return size;
    endfunction

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        if (we) begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return ok;
    endfunction

    function automatic logic is_crossing(input logic [1:0] off, input logic [2:0] size);
        return ({2'b00, off} + {1'b0, size}) > 4'd4;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the load/store unit.
// Ports:
//   off           byte offset of the access within its first word
//   size          access size in bytes (1, 2, 4)
//   phase         0 = first word of the access, 1 = following word
//   funct3        width/extension code of the access
//   mem_rdata     word currently read from memory
//   store_data    store data, access byte 0 in bits [7:0]
//   load_buf      load bytes gathered so far, access byte k in lane k
//   merged_wdata  mem_rdata with this phase's lanes replaced by store bytes
//   load_buf_next load_buf updated with this phase's bytes from mem_rdata
//   load_data     load_buf sign/zero extended according to funct3
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  size,
    input  logic        phase,
    input  logic [2:0]  funct3,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] store_data,
    input  logic [31:0] load_buf,
    output logic [31:0] merged_wdata,
    output logic [31:0] load_buf_next,
    output logic [31:0] load_data
);

    // Memory lane l carries access byte k; in the second word the count
    // continues from where the first word stopped (4 - off bytes in).
    always_comb begin
        int k;
        k             = 0;
        merged_wdata  = mem_rdata;
        load_buf_next = load_buf;
        for (int lane = 0; lane < 4; lane++) begin
            k = phase ? (4 - int'(off) + lane) : (lane - int'(off));
            if (k >= 0 && k < int'(size)) begin
                merged_wdata[8*lane +: 8] = store_data[8*k +: 8];
                load_buf_next[8*k +: 8]   = mem_rdata[8*lane +: 8];
            end
        end
    end

    always_comb begin
        load_data = 32'h0;
        case (funct3)
            F3_B:    load_data = {{24{load_buf[7]}}, load_buf[7:0]};
            F3_H:    load_data = {{16{load_buf[15]}}, load_buf[15:0]};
            F3_W:    load_data = load_buf;
            F3_BU:   load_data = {24'h0, load_buf[7:0]};
            F3_HU:   load_data = {16'h0, load_buf[15:0]};
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time RV32I load/store engine in front of a
// word-addressed memory (combinational read, word write, no byte enables).
// Sub-word stores are read-modify-write; word-crossing accesses take two
// memory cycles (or are rejected when ALLOW_MISALIGNED = 0).
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_funct3       store flag, RV32I width code
//   req_addr, req_wdata      byte address, store data (low bytes)
//   rsp_valid                one-cycle completion pulse
//   rsp_rdata, rsp_err       extended load data, error flag
//   mem_we, mem_addr         word write enable, word-aligned address
//   mem_wdata, mem_rdata     merged write word, combinational read word
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// ACC0  | access to the word holding the first byte
// ACC1  | access to the following word (crossing accesses only)
// RESP  | rsp_valid pulse with load data or error
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] buf_q;

    logic        accept;
    logic        req_bad;
    logic [2:0]  size_q;
    logic        cross_q;
    logic [31:0] merged_wdata;
    logic [31:0] buf_next;
    logic [31:0] load_data;

    assign accept  = req_valid && req_ready;
    assign req_bad = !funct3_legal(req_we, req_funct3) ||
                     ((ALLOW_MISALIGNED == 0) &&
                      is_crossing(req_addr[1:0], access_size(req_funct3)));
    assign size_q  = access_size(f3_q);
    assign cross_q = is_crossing(addr_q[1:0], size_q);

    lsu_lane_align u_align (
        .off           (addr_q[1:0]),
        .size          (size_q),
        .phase         (state_q == ACC1),
        .funct3        (f3_q),
        .mem_rdata     (mem_rdata),
        .store_data    (wdata_q),
        .load_buf      (buf_q),
        .merged_wdata  (merged_wdata),
        .load_buf_next (buf_next),
        .load_data     (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_bad ? RESP : ACC0;
            ACC0:    state_d = cross_q ? ACC1 : RESP;
            ACC1:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch and load byte buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            buf_q   <= 32'h0;
        end else if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= req_bad;
            buf_q   <= 32'h0;
        end else if ((state_q == ACC0 || state_q == ACC1) && !we_q) begin
            buf_q   <= buf_next;
        end
    end

    // All outputs decode from state so reset clears them immediately.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        case (state_q)
            IDLE: req_ready = !rst;
            ACC0: begin
                mem_addr = {addr_q[31:2], 2'b00};
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = merged_wdata;
                end
            end
            ACC1: begin
                mem_addr = {addr_q[31:2] + 30'd1, 2'b00};
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = merged_wdata;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (!we_q && !err_q) rsp_rdata = load_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid_m, req_valid_n, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;

    logic        m_ready, m_rsp_valid, m_rsp_err, m_mem_we;
    logic [31:0] m_rsp_rdata, m_mem_addr, m_mem_wdata, m_mem_rdata;
    logic        n_ready, n_rsp_valid, n_rsp_err, n_mem_we;
    logic [31:0] n_rsp_rdata, n_mem_addr, n_mem_wdata, n_mem_rdata;

    load_store_unit #(.ALLOW_MISALIGNED(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid_m), .req_ready(m_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(m_rsp_valid), .rsp_rdata(m_rsp_rdata),
        .rsp_err(m_rsp_err), .mem_we(m_mem_we), .mem_addr(m_mem_addr),
        .mem_wdata(m_mem_wdata), .mem_rdata(m_mem_rdata)
    );

    load_store_unit #(.ALLOW_MISALIGNED(0)) dut_nm (
        .clk(clk), .rst(rst), .req_valid(req_valid_n), .req_ready(n_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(n_rsp_valid), .rsp_rdata(n_rsp_rdata),
        .rsp_err(n_rsp_err), .mem_we(n_mem_we), .mem_addr(n_mem_addr),
        .mem_wdata(n_mem_wdata), .mem_rdata(n_mem_rdata)
    );

    // Memory model for the main instance; the no-misalign instance sees a constant word.
    logic [31:0] mem [16];
    logic        pl_we;
    logic [3:0]  pl_idx;
    logic [31:0] pl_data;
    assign m_mem_rdata = mem[m_mem_addr[5:2]];
    assign n_mem_rdata = 32'hCAFEF00D;

    always @(posedge clk) begin
        if (pl_we) mem[pl_idx] <= pl_data;
        else if (m_mem_we) mem[m_mem_addr[5:2]] <= m_mem_wdata;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q_m[$];
    exp_t q_n[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int we_m = 0;
    int we_n = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (m_mem_we) we_m++;
        if (n_mem_we) we_n++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every response pulse pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (m_rsp_valid) begin
            if (q_m.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL m_unexpected_rsp actual=rsp_valid rdata=%h required=no_rsp", m_rsp_rdata);
            end else begin
                e = q_m.pop_front();
                chk("m_rdata", m_rsp_rdata, e.rdata);
                chk("m_err", 32'(m_rsp_err), 32'(e.err));
                chk("m_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (n_rsp_valid) begin
            if (q_n.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL n_unexpected_rsp actual=rsp_valid rdata=%h required=no_rsp", n_rsp_rdata);
            end else begin
                e = q_n.pop_front();
                chk("n_rdata", n_rsp_rdata, e.rdata);
                chk("n_err", 32'(n_rsp_err), 32'(e.err));
                chk("n_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_idx = idx; pl_data = data;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // lat: cycle of rsp_valid counted from the accept edge (ACC0 = cycle 1).
    task automatic issue(input bit nm, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input int exp_we, input bit ck_addr,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input string name);
        int   a, we0, n, left;
        logic ok;
        exp_t e;
        @(posedge clk); #1;
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        if (nm) req_valid_n = 1'b1; else req_valid_m = 1'b1;
        n = 0; ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = nm ? n_ready : m_ready;
            n++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_accept_timeout actual=ready_low required=ready_high", name);
            req_valid_m = 1'b0; req_valid_n = 1'b0;
            return;
        end
        we0 = nm ? we_n : we_m;
        @(posedge clk); #1;
        req_valid_m = 1'b0; req_valid_n = 1'b0;
        a = cyc;
        e.rdata = exp_rd; e.err = exp_err; e.cyc = a + lat - 1;
        if (nm) q_n.push_back(e); else q_m.push_back(e);
        if (ck_addr) begin
            @(negedge clk);
            chk({name, "_addr0"}, nm ? n_mem_addr : m_mem_addr, a0);
            if (lat == 3) begin
                @(negedge clk);
                chk({name, "_addr1"}, nm ? n_mem_addr : m_mem_addr, a1);
            end
        end
        n = 0;
        left = nm ? q_n.size() : q_m.size();
        while (left != 0 && n < 20) begin
            @(posedge clk);
            n++;
            left = nm ? q_n.size() : q_m.size();
        end
        if (left != 0) begin
            checks++; errors++;
            $display("FAIL %s_rsp_timeout actual=no_rsp required=rsp_valid", name);
            if (nm) q_n.delete(); else q_m.delete();
        end
        chk({name, "_we_cycles"}, 32'((nm ? we_n : we_m) - we0), 32'(exp_we));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1);
    end

    initial begin
        req_valid_m = 1'b0; req_valid_n = 1'b0; req_we = 1'b0;
        req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        pl_we = 1'b0; pl_idx = 4'h0; pl_data = 32'h0;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(m_ready), 32'h0);
        chk("rst_rsp_valid", 32'(m_rsp_valid), 32'h0);
        chk("rst_rsp_err", 32'(m_rsp_err), 32'h0);
        chk("rst_rsp_rdata", m_rsp_rdata, 32'h0);
        chk("rst_mem_we", 32'(m_mem_we), 32'h0);
        chk("rst_mem_addr", m_mem_addr, 32'h0);
        chk("rst_mem_wdata", m_mem_wdata, 32'h0);
        chk("rst_nm_ready", 32'(n_ready), 32'h0);
        chk("rst_nm_wdata", n_mem_wdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(m_ready), 32'h1);

        preload(4'd4, 32'h11223344);
        preload(4'd5, 32'hAABBCCDD);
        preload(4'd15, 32'h55667788);
        preload(4'd0, 32'h99AABBCC);

        // Loads
        issue(0, 0, F3_W,  32'h10, 0, 32'h11223344, 0, 2, 0, 1, 32'h10, 0, "lw_10");
        issue(0, 0, F3_B,  32'h13, 0, 32'h00000011, 0, 2, 0, 1, 32'h10, 0, "lb_13");
        issue(0, 0, F3_B,  32'h17, 0, 32'hFFFFFFAA, 0, 2, 0, 1, 32'h14, 0, "lb_17");
        issue(0, 0, F3_BU, 32'h17, 0, 32'h000000AA, 0, 2, 0, 1, 32'h14, 0, "lbu_17");
        issue(0, 0, F3_HU, 32'h16, 0, 32'h0000AABB, 0, 2, 0, 1, 32'h14, 0, "lhu_16");
        issue(0, 0, F3_H,  32'h16, 0, 32'hFFFFAABB, 0, 2, 0, 1, 32'h14, 0, "lh_16");
        issue(0, 0, F3_W,  32'h12, 0, 32'hCCDD1122, 0, 3, 0, 1, 32'h10, 32'h14, "lw_cross_12");
        issue(0, 0, F3_W,  32'hFFFFFFFE, 0, 32'hBBCC5566, 0, 3, 0, 1, 32'hFFFFFFFC, 32'h0, "lw_wrap");

        // Errors
        issue(0, 0, 3'b011, 32'h10, 0, 32'h0, 1, 1, 0, 0, 0, 0, "lw_bad_f3");
        issue(0, 1, 3'b100, 32'h10, 32'hFF, 32'h0, 1, 1, 0, 0, 0, 0, "sb_bad_f3");
        chk("sb_bad_f3_mem10", mem[4], 32'h11223344);

        // Stores
        issue(0, 1, F3_B, 32'h11, 32'h123456EE, 32'h0, 0, 2, 1, 1, 32'h10, 0, "sb_11");
        chk("sb_11_mem10", mem[4], 32'h1122EE44);
        chk("sb_11_mem14", mem[5], 32'hAABBCCDD);
        issue(0, 1, F3_W, 32'h14, 32'hDEADBEEF, 32'h0, 0, 2, 1, 1, 32'h14, 0, "sw_14");
        chk("sw_14_mem14", mem[5], 32'hDEADBEEF);

        preload(4'd4, 32'h11223344);
        preload(4'd5, 32'hAABBCCDD);
        issue(0, 1, F3_H, 32'h13, 32'h0000BEEF, 32'h0, 0, 3, 2, 1, 32'h10, 32'h14, "sh_cross_13");
        chk("sh_cross_mem10", mem[4], 32'hEF223344);
        chk("sh_cross_mem14", mem[5], 32'hAABBCCBE);

        // Reset during ACC1 of a crossing SW 0x13
        @(posedge clk); #1;
        req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h13; req_wdata = 32'h01020304;
        req_valid_m = 1'b1;
        @(negedge clk);
        chk("rstmid_ready", 32'(m_ready), 32'h1);
        @(posedge clk); #1;
        req_valid_m = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_acc1_we", 32'(m_mem_we), 32'h1);
        chk("rstmid_acc1_addr", m_mem_addr, 32'h14);
        rst = 1'b1;
        #1;
        chk("rstmid_we_drop", 32'(m_mem_we), 32'h0);
        chk("rstmid_ready_low", 32'(m_ready), 32'h0);
        repeat (3) @(negedge clk);
        chk("rstmid_mem14_kept", mem[5], 32'hAABBCCBE);
        chk("rstmid_mem10_first", mem[4], 32'h04223344);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready_back", 32'(m_ready), 32'h1);
        issue(0, 0, F3_W, 32'h14, 0, 32'hAABBCCBE, 0, 2, 0, 1, 32'h14, 0, "lw_after_rst");

        // ALLOW_MISALIGNED = 0 instance
        issue(1, 0, F3_W, 32'h10, 0, 32'hCAFEF00D, 0, 2, 0, 1, 32'h10, 0, "nm_lw_aligned");
        issue(1, 0, F3_W, 32'h12, 0, 32'h0, 1, 1, 0, 0, 0, 0, "nm_lw_cross");
        issue(1, 1, F3_H, 32'h13, 32'hBEEF, 32'h0, 1, 1, 0, 0, 0, 0, "nm_sh_cross");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
